reloj_alarma_param: RTL and testbench

- Parametrised successor of the team's BCD wall clock, for the digital-clock project board.
- Keeps HH:MM:SS time in BCD from a single system clock and drives four BCD digits plus a seconds LED.
- New over the previous generation:
  - explicit run / set-time / set-alarm modes
  - 12/24-hour display
  - programmable alarm with auto-timeout and snooze
  - fully synchronous single-clock design; no derived clocks.

---
 rtl/reloj_alarma_param.sv | 225 ++++++++++++++++++++++
 tb/tb_reloj_alarma_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reloj_alarma_param.sv
// BCD HH:MM:SS wall clock with set-time/set-alarm modes, 12/24h display and snoozable alarm.
// Single clock; display outputs are registered one cycle after any internal update.
module reloj_alarma_param #(
  parameter int DIV        = 50_000_000,
  parameter int ALARM_SECS = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setmin,
  input  logic       sethor,
  input  logic [1:0] modo,
  input  logic       mode_12h,
  input  logic       alarm_en,
  input  logic       snooze,
  output logic       ledseg,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic [3:0] bcd4,
  output logic       pm,
  output logic       alarma
);

  localparam int DW           = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int OW           = $clog2(ALARM_SECS + 1);
  localparam int SW           = $clog2(SNOOZE_TICKS + 1);

  typedef enum logic [1:0] {
    A_IDLE,
    A_RING,
    A_SNOOZE
  } alarm_state_t;

  // Two-digit BCD increment with wrap to 00 after the given maximum.
  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Returns {pm, tens, units} for a 24h BCD hour shown on a 12h face.
  function automatic logic [8:0] to_12h(input logic [7:0] h);
    logic [4:0] b;
    logic [4:0] r;
    logic       p;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    p = (b >= 5'd12);
    if (b == 5'd0)       r = 5'd12;
    else if (b > 5'd12)  r = b - 5'd12;
    else                 r = b;
    if (r >= 5'd10) return {p, 4'd1, 4'(r - 5'd10)};
    return {p, 4'd0, r[3:0]};
  endfunction

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [7:0]    t_sec, t_min, t_hour;
  logic [7:0]    al_min, al_hour;
  logic          setmin_q, sethor_q, snooze_q;
  logic          setmin_e, sethor_e, snooze_e;
  logic          set_time, set_alarm, run_tick;
  logic [7:0]    min_inc, hour_inc, next_min, next_hour;
  logic          trigger;

  alarm_state_t  a_state, a_state_n;
  logic [OW-1:0] on_cnt, on_cnt_n;
  logic [SW-1:0] sn_cnt, sn_cnt_n;

  logic [7:0]    src_min, src_hour, disp_hour;
  logic          disp_pm;
  logic [8:0]    h12;

  assign tick      = (div_cnt == DW'(DIV - 1));
  assign setmin_e  = setmin & ~setmin_q;
  assign sethor_e  = sethor & ~sethor_q;
  assign snooze_e  = snooze & ~snooze_q;
  assign set_time  = (modo == 2'b01);
  assign set_alarm = (modo == 2'b10);
  assign run_tick  = tick & ~set_time;

  always_comb begin
    min_inc   = inc_bcd(t_min, 8'h59);
    hour_inc  = inc_bcd(t_hour, 8'h23);
    next_min  = (t_sec == 8'h59) ? min_inc : t_min;
    next_hour = (t_sec == 8'h59 && t_min == 8'h59) ? hour_inc : t_hour;
  end

  // Only a running tick that lands on HH:MM:00 can fire; alarm edits never do.
  assign trigger = run_tick & alarm_en & (t_sec == 8'h59)
                 & (next_min == al_min) & (next_hour == al_hour);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      setmin_q <= 1'b0;
      sethor_q <= 1'b0;
      snooze_q <= 1'b0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + DW'(1);
      setmin_q <= setmin;
      sethor_q <= sethor;
      snooze_q <= snooze;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_sec   <= 8'h00;
      t_min   <= 8'h00;
      t_hour  <= 8'h00;
      al_min  <= 8'h00;
      al_hour <= 8'h00;
    end else begin
      if (set_time) begin
        if (setmin_e) begin
          t_min <= min_inc;
          t_sec <= 8'h00;
        end
        if (sethor_e) t_hour <= hour_inc;
      end else if (tick) begin
        t_sec  <= inc_bcd(t_sec, 8'h59);
        t_min  <= next_min;
        t_hour <= next_hour;
      end
      if (set_alarm) begin
        if (setmin_e) al_min  <= inc_bcd(al_min, 8'h59);
        if (sethor_e) al_hour <= inc_bcd(al_hour, 8'h23);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_state <= A_IDLE;
      on_cnt  <= '0;
      sn_cnt  <= '0;
    end else begin
      a_state <= a_state_n;
      on_cnt  <= on_cnt_n;
      sn_cnt  <= sn_cnt_n;
    end
  end

  always_comb begin
    a_state_n = a_state;
    on_cnt_n  = on_cnt;
    sn_cnt_n  = sn_cnt;
    if (!alarm_en) begin
      a_state_n = A_IDLE;
      on_cnt_n  = '0;
      sn_cnt_n  = '0;
    end else begin
      case (a_state)
        A_IDLE: begin
          if (trigger) begin
            a_state_n = A_RING;
            on_cnt_n  = OW'(ALARM_SECS);
          end
        end
        A_RING: begin
          if (snooze_e) begin
            a_state_n = A_SNOOZE;
            sn_cnt_n  = SW'(SNOOZE_TICKS);
          end else if (trigger) begin
            on_cnt_n = OW'(ALARM_SECS);
          end else if (tick) begin
            if (on_cnt <= OW'(1)) begin
              a_state_n = A_IDLE;
              on_cnt_n  = '0;
            end else begin
              on_cnt_n = on_cnt - OW'(1);
            end
          end
        end
        A_SNOOZE: begin
          if (trigger || (tick && sn_cnt <= SW'(1))) begin
            a_state_n = A_RING;
            on_cnt_n  = OW'(ALARM_SECS);
            sn_cnt_n  = '0;
          end else if (tick) begin
            sn_cnt_n = sn_cnt - SW'(1);
          end
        end
        default: begin
          a_state_n = A_IDLE;
        end
      endcase
    end
  end

  assign alarma = (a_state == A_RING);

  always_comb begin
    src_min   = set_alarm ? al_min  : t_min;
    src_hour  = set_alarm ? al_hour : t_hour;
    h12       = to_12h(src_hour);
    disp_hour = src_hour;
    disp_pm   = 1'b0;
    if (mode_12h) begin
      disp_hour = h12[7:0];
      disp_pm   = h12[8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd1   <= 4'd0;
      bcd2   <= 4'd0;
      bcd3   <= 4'd0;
      bcd4   <= 4'd0;
      pm     <= 1'b0;
      ledseg <= 1'b0;
    end else begin
      bcd1   <= src_min[3:0];
      bcd2   <= src_min[7:4];
      bcd3   <= disp_hour[3:0];
      bcd4   <= disp_hour[7:4];
      pm     <= disp_pm;
      ledseg <= (div_cnt < DW'(DIV / 2));
    end
  end

endmodule

// File: tb/tb_reloj_alarma_param.sv
// Directed bench for reloj_alarma_param with DIV=4 (one tick every 4 clocks).
module tb_reloj_alarma_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       setmin = 1'b0;
  logic       sethor = 1'b0;
  logic [1:0] modo = 2'b00;
  logic       mode_12h = 1'b0;
  logic       alarm_en = 1'b0;
  logic       snooze = 1'b0;
  logic       ledseg, pm, alarma;
  logic [3:0] bcd1, bcd2, bcd3, bcd4;
  int         total = 0;
  int         passed = 0;
  int         rc = 0;
  logic       seen;

  always #5 clk = ~clk;

  // Clocks since reset release; a tick lands on every posedge where rc becomes a multiple of 4.
  always @(posedge clk) begin
    if (rst) rc <= 0;
    else     rc <= rc + 1;
  end

  reloj_alarma_param #(.DIV(4), .ALARM_SECS(60), .SNOOZE_MIN(5)) dut (
    .clk(clk), .rst(rst), .setmin(setmin), .sethor(sethor), .modo(modo),
    .mode_12h(mode_12h), .alarm_en(alarm_en), .snooze(snooze), .ledseg(ledseg),
    .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4), .pm(pm), .alarma(alarma)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      setmin = 1'b1; cyc(1);
      setmin = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_hor(input int n);
    for (int i = 0; i < n; i++) begin
      sethor = 1'b1; cyc(1);
      sethor = 1'b0; cyc(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2);
    rst = 1'b0;
  endtask

  task automatic align();
    for (int i = 0; i < 4 && (rc % 4) != 0; i++) cyc(1);
  endtask

  task automatic watch(input int n, output logic hit);
    hit = 1'b0;
    repeat (n) begin
      cyc(1);
      if (alarma) hit = 1'b1;
    end
  endtask

  function automatic logic [15:0] disp();
    return {bcd4, bcd3, bcd2, bcd1};
  endfunction

  // Alarm at 00:02, time 00:00:00, armed, run mode entered right after a tick.
  task automatic setup_alarm();
    modo = 2'b00; mode_12h = 1'b0; alarm_en = 1'b0; snooze = 1'b0;
    do_reset();
    modo = 2'b10;
    pulse_min(2);
    chk("alarm_edit_display", 32'(disp()), 32'h0002);
    modo = 2'b01;
    pulse_min(60);
    alarm_en = 1'b1;
    align();
    modo = 2'b00;
  endtask

  initial begin
    // Reset values and the seconds LED duty cycle.
    cyc(3);
    chk("reset_display", 32'(disp()), 32'h0000);
    chk("reset_ledseg", 32'(ledseg), 32'd0);
    chk("reset_pm", 32'(pm), 32'd0);
    chk("reset_alarma", 32'(alarma), 32'd0);
    rst = 1'b0;
    cyc(1); chk("led_c1", 32'(ledseg), 32'd1);
    cyc(1); chk("led_c2", 32'(ledseg), 32'd1);
    cyc(1); chk("led_c3", 32'(ledseg), 32'd0);
    cyc(1); chk("led_c4", 32'(ledseg), 32'd0);
    cyc(4 * 240 - 4 + 1);
    chk("run_240_ticks", 32'(disp()), 32'h0004);

    // Set time: minute wrap without hour carry, then 23:59 and midnight rollover.
    modo = 2'b01;
    pulse_min(56);
    chk("min_wrap_no_carry", 32'(disp()), 32'h0000);
    pulse_min(59);
    chk("min59_hours_kept", 32'(disp()), 32'h0059);
    pulse_hor(23);
    chk("set_2359", 32'(disp()), 32'h2359);
    align();
    modo = 2'b00;
    cyc(4 * 59 + 1);
    chk("after_59_ticks", 32'(disp()), 32'h2359);
    cyc(4);
    chk("midnight_rollover", 32'(disp()), 32'h0000);

    // 12-hour display.
    modo = 2'b01;
    mode_12h = 1'b1;
    cyc(1);
    chk("h12_0000", 32'({pm, disp()}), 32'h0_1200);
    pulse_min(5);
    chk("h12_0005", 32'({pm, disp()}), 32'h0_1205);
    pulse_min(55);
    pulse_hor(12);
    chk("h12_1200", 32'({pm, disp()}), 32'h1_1200);
    pulse_hor(1);
    pulse_min(30);
    chk("h12_1330", 32'({pm, disp()}), 32'h1_0130);
    mode_12h = 1'b0;
    cyc(1);
    chk("h24_1330", 32'({pm, disp()}), 32'h0_1330);
    mode_12h = 1'b1;
    pulse_hor(10);
    chk("h12_2330", 32'({pm, disp()}), 32'h1_1130);
    mode_12h = 1'b0;

    // Alarm fires on tick 120 and auto-clears 60 ticks later.
    setup_alarm();
    cyc(479);
    chk("alarm_before_tick120", 32'(alarma), 32'd0);
    cyc(1);
    chk("alarm_rise_tick120", 32'(alarma), 32'd1);
    cyc(1);
    chk("time_at_alarm", 32'(disp()), 32'h0002);
    cyc(720 - 481 - 1);
    chk("alarm_still_on", 32'(alarma), 32'd1);
    cyc(1);
    chk("alarm_timeout", 32'(alarma), 32'd0);

    // No alarm while set-time mode is held.
    setup_alarm();
    modo = 2'b01;
    watch(4 * 130, seen);
    chk("no_alarm_in_set_time", 32'(seen), 32'd0);

    // Snooze: ignored while quiet, re-asserts 300 ticks after press, alarm_en=0 cancels.
    setup_alarm();
    cyc(400);
    snooze = 1'b1; cyc(1);
    snooze = 1'b0; cyc(1);
    cyc(77);
    chk("snooze_idle_ignored_pre", 32'(alarma), 32'd0);
    cyc(1);
    chk("alarm_rise_after_idle_snooze", 32'(alarma), 32'd1);
    cyc(20);
    snooze = 1'b1; cyc(1);
    snooze = 1'b0;
    chk("snooze_clears", 32'(alarma), 32'd0);
    cyc(1700 - 501 - 1);
    chk("snooze_wait_299", 32'(alarma), 32'd0);
    cyc(1);
    chk("snooze_reassert_300", 32'(alarma), 32'd1);
    snooze = 1'b1; cyc(1);
    snooze = 1'b0;
    chk("snooze_again_clears", 32'(alarma), 32'd0);
    cyc(39);
    alarm_en = 1'b0;
    watch(4 * 320, seen);
    chk("disable_cancels_snooze", 32'(seen), 32'd0);

    // Reset while ringing.
    setup_alarm();
    cyc(480);
    chk("pre_rst_ringing", 32'(alarma), 32'd1);
    rst = 1'b1; cyc(1);
    chk("rst_ring_alarma", 32'(alarma), 32'd0);
    chk("rst_ring_display", 32'({pm, ledseg, disp()}), 32'h0);
    rst = 1'b0;
    watch(4 * 100, seen);
    chk("rst_ring_no_later_alarm", 32'(seen), 32'd0);

    // Reset during a snooze countdown.
    setup_alarm();
    cyc(480);
    snooze = 1'b1; cyc(1);
    snooze = 1'b0;
    cyc(200);
    rst = 1'b1; cyc(1);
    chk("rst_snooze_alarma", 32'(alarma), 32'd0);
    chk("rst_snooze_display", 32'({pm, ledseg, disp()}), 32'h0);
    rst = 1'b0;
    watch(4 * 310, seen);
    chk("rst_snooze_no_reassert", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
